uart_tx_fifo: RTL

Parametrised UART transmitter with an internal transmit FIFO. It serialises words written over a valid/ready interface onto `TxD` at a fixed baud rate. Data width, parity mode, stop-bit count and FIFO depth are configurable. It replaces the fixed 8N1 single-word transmitter in the board-level UART top. Upstream producers (debounced switch capture, test pattern sources) stream bytes without polling a busy flag.

---
 rtl/uart_tx_fifo.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a valid/ready FIFO.
// Frames are emitted back to back while words are queued.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 TxD,
  output logic                 tx_busy,
  output logic [CW-1:0]        fifo_count
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int BW = $clog2(BAUD_DIV);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic par_q, par_d;
  logic txd_q, txd_d;
  logic busy_q, busy_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic push;
  logic pop;
  logic tick;
  logic [DATA_BITS-1:0] head;

  assign data_ready = (count_q != DEPTH);
  assign push = data_valid && data_ready;
  assign head = mem_q[rd_ptr_q];
  assign tick = (baud_q == BAUD_LAST);

  assign TxD = txd_q;
  assign tx_busy = busy_q;
  assign fifo_count = count_q;

  // FIFO storage; contents need no reset, pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10: count_d = count_q + 1'b1;
      2'b01: count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Frame sequencer: baud timing, bit shifting, FIFO pop
  always_comb begin
    state_d = state_q;
    baud_d = tick ? '0 : baud_q + 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    par_d = par_q;
    txd_d = txd_q;
    busy_d = busy_q;
    pop = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        txd_d = 1'b1;
        busy_d = 1'b0;
        if (count_q != '0) begin
          pop = 1'b1;
          shift_d = head;
          par_d = (PARITY == 1) ? ~^head : ^head;
          txd_d = 1'b0;
          busy_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          txd_d = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              txd_d = par_q;
              state_d = S_PAR;
            end else begin
              txd_d = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            txd_d = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (tick) begin
          txd_d = 1'b1;
          bit_d = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (bit_q != STOP_LAST) begin
            bit_d = bit_q + 1'b1;
          end else if (count_q != '0) begin
            pop = 1'b1;
            shift_d = head;
            par_d = (PARITY == 1) ? ~^head : ^head;
            txd_d = 1'b0;
            state_d = S_START;
          end else begin
            txd_d = 1'b1;
            busy_d = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        txd_d = 1'b1;
        busy_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset forces the line idle at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      txd_q <= 1'b1;
      busy_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      par_q <= par_d;
      txd_q <= txd_d;
      busy_q <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end

endmodule
